keypad_scan_debounce: RTL and testbench
=======================================

# keypad_scan_debounce

Row-scanning and debounce stage for the 4x4 hex keypad. Drives the active-low row lines `r_sel`, samples the already-synchronized active-low column inputs `col_sync`, and debounces press and release. It emits one single-cycle `key_valid` strobe with a 4-bit hex `key_code` per physical key press. It sits between the column synchronizer and the two-digit display/history logic inside `top`, and is clocked by `int_osc`.

## Interface
- `SCAN_DIV`, default 4: `int_osc` cycles each row is driven before advancing. Minimum 2.
- `DB_CYCLES`, default 3: consecutive stable samples needed to accept a press or a release. Minimum 2.
- `int_osc`  in  1  system clock.
- `reset`  in  1  reset; synchronous, active-high.
- `col_sync`  in  4  synchronized column inputs; active-low; bit i = column i.
- `r_sel`  out  4  row drive; one-cold, active-low; bit i = row i.
- `key_code`  out  4  hex value of the last accepted key.
- `key_valid`  out  1  one-cycle strobe marking a newly accepted key.
- `key_held`  out  1  high while the accepted key remains pressed.

## Operation
- All outputs are registered.
- Reset values:
  - `r_sel` = 4'b1110 (row 0 driven)
  - `key_code` = 0, `key_valid` = 0, `key_held` = 0
  - state SCAN; dwell and debounce counters = 0
- States: SCAN, DEBOUNCE, HELD, RELEASE.
- SCAN:
  - The dwell counter counts 0..SCAN_DIV-1.
  - In the last dwell cycle (count = SCAN_DIV-1), `col_sync` is sampled.
  - If all columns are high, the row advances 0→1→2→3→0 and `r_sel` rotates left with wrap-around.
  - If any column is low, the current row and the lowest-index low column are latched. The state goes to DEBOUNCE with debounce count = 1, and the row is frozen.
- DEBOUNCE:
  - Each cycle the latched column is checked.
  - If it is high, the state returns to SCAN. The row advances past the latched row and the dwell counter restarts at 0. No strobe is issued.
  - If it is low, the count increments.
  - When the count reaches DB_CYCLES: load `key_code`, pulse `key_valid`, set `key_held`, and go to HELD.
- HELD:
  - The row stays frozen and `key_held` = 1.
  - Other columns and other keys are ignored (no rollover).
  - When the latched column reads high, the state goes to RELEASE with release count = 1.
- RELEASE:
  - If the latched column reads low again, the state returns to HELD. No new strobe is issued.
  - If it stays high until the count reaches DB_CYCLES, `key_held` clears and the state goes to SCAN. The row advances and the dwell counter restarts at 0.
- `key_code` mapping, rows 0-3 × columns 0-3:
  - Row 0: 1, 2, 3, A
  - Row 1: 4, 5, 6, B
  - Row 2: 7, 8, 9, C
  - Row 3: E, 0, F, D
- `key_code` holds its value until the next accepted press. It does not clear on release.
- Simultaneous keys in one row at detection: the lowest column wins.

## Timing
- `r_sel` changes on the edge after dwell count SCAN_DIV-1. Each row is therefore low for exactly SCAN_DIV cycles. A full idle sweep takes 4·SCAN_DIV cycles.
- Press latency: with the detecting sample at edge t and the column held low, `key_valid` and `key_held` rise and `key_code` updates at edge t+DB_CYCLES-1. `key_valid` falls one edge later.
- Release latency: with the first high sample at edge r, `key_held` falls at edge r+DB_CYCLES-1. `r_sel` advances on the same edge.
- Any glitch shorter than DB_CYCLES cycles, on either press or release, produces no strobe and no `key_held` change.
- `reset` asserted in any state returns every output and state to its reset value on the next edge. A key still held when `reset` deasserts is re-detected from SCAN and produces a fresh strobe.

## Test plan
Parameters for all scenarios: SCAN_DIV=4, DB_CYCLES=3, 10 ns clock. The bench models the keypad: column c reads low only while its key is pressed and its row is driven low.

- Reset, idle sweep: hold `reset` 2 cycles with no key pressed → `r_sel` cycles 1110, 1101, 1011, 0111, 1110, each value for exactly 4 cycles; `key_valid` and `key_held` stay 0.
- Clean press of row 1 / column 0 for 40 cycles → exactly one `key_valid` pulse with `key_code` = 4. `key_held` stays high through the hold. `r_sel` stays frozen at 1101 until 3 cycles after release, then advances to 1011.
- Press bounce: row 2 / column 2 low for 1 cycle, then high → no `key_valid`; scanning resumes at row 3 (`r_sel` = 0111).
- Release bounce: hold row 3 / column 1 (`key_code` = 0), then release as high 2 cycles / low 1 cycle / high 10 cycles → `key_held` stays 1 through the bounce and falls only after the final 3 high cycles; exactly one strobe overall.
- Rollover and priority: hold row 0 / column 3 (A); while it is held, press row 2 / column 0 → no second strobe. After both are released, press row 0 / columns 1 and 2 together → `key_code` = 2.
- Reset mid-HELD: assert `reset` while key 9 is held → on the next edge `key_held` = 0, `key_valid` = 0, `key_code` = 0, `r_sel` = 1110. After reset deasserts with the key still held, a new strobe arrives with `key_code` = 9.

Source files
------------

// File: rtl/keypad_scan_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | keypad_scan_debounce: 4x4 keypad row scanner with press/release debounce.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module keypad_scan_debounce #(
  parameter int SCAN_DIV  = 4,
  parameter int DB_CYCLES = 3
) (
  input  logic       int_osc,
  input  logic       reset,
  input  logic [3:0] col_sync,
  output logic [3:0] r_sel,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int c_DW = $clog2(SCAN_DIV);
  localparam int c_CW = $clog2(DB_CYCLES + 1);
  localparam logic [c_DW-1:0] c_DWELL_LAST = c_DW'(SCAN_DIV - 1);
  localparam logic [c_CW-1:0] c_CNT_LAST   = c_CW'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    S_SCAN     = 2'd0,
    S_DEBOUNCE = 2'd1,
    S_HELD     = 2'd2,
    S_RELEASE  = 2'd3
  } state_t;

  state_t          r_state, w_state;
  logic [c_DW-1:0] r_dwell, w_dwell;
  logic [c_CW-1:0] r_cnt, w_cnt;
  logic [1:0]      r_row, w_row;
  logic [1:0]      r_col, w_col;
  logic [3:0]      w_sel;
  logic [3:0]      w_code;
  logic            w_valid;
  logic            w_held;
  logic            w_hit;
  logic            w_any;
  logic [1:0]      w_low_col;

  function automatic logic [3:0] f_map(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    case ({row, col})
      4'd0:  code = 4'h1;
      4'd1:  code = 4'h2;
      4'd2:  code = 4'h3;
      4'd3:  code = 4'hA;
      4'd4:  code = 4'h4;
      4'd5:  code = 4'h5;
      4'd6:  code = 4'h6;
      4'd7:  code = 4'hB;
      4'd8:  code = 4'h7;
      4'd9:  code = 4'h8;
      4'd10: code = 4'h9;
      4'd11: code = 4'hC;
      4'd12: code = 4'hE;
      4'd13: code = 4'h0;
      4'd14: code = 4'hF;
      default: code = 4'hD;
    endcase
    return code;
  endfunction

  assign w_hit = ~col_sync[r_col];
  assign w_any = ~&col_sync;

  // Lowest-index low column wins when several keys in the row are down.
  always_comb begin
    w_low_col = 2'd3;
    if (!col_sync[0])      w_low_col = 2'd0;
    else if (!col_sync[1]) w_low_col = 2'd1;
    else if (!col_sync[2]) w_low_col = 2'd2;
  end

  always_comb begin
    w_state = r_state;
    w_dwell = r_dwell;
    w_cnt   = r_cnt;
    w_row   = r_row;
    w_col   = r_col;
    w_sel   = r_sel;
    w_code  = key_code;
    w_valid = 1'b0;
    w_held  = key_held;
    case (r_state)
      S_SCAN: begin
        if (r_dwell == c_DWELL_LAST) begin
          w_dwell = '0;
          if (w_any) begin
            w_col   = w_low_col;
            w_cnt   = c_CW'(1);
            w_state = S_DEBOUNCE;
          end else begin
            w_row = r_row + 2'd1;
            w_sel = {r_sel[2:0], r_sel[3]};
          end
        end else begin
          w_dwell = r_dwell + c_DW'(1);
        end
      end
      S_DEBOUNCE: begin
        if (!w_hit) begin
          w_state = S_SCAN;
          w_row   = r_row + 2'd1;
          w_sel   = {r_sel[2:0], r_sel[3]};
          w_dwell = '0;
          w_cnt   = '0;
        end else if (r_cnt == c_CNT_LAST) begin
          w_code  = f_map(r_row, r_col);
          w_valid = 1'b1;
          w_held  = 1'b1;
          w_state = S_HELD;
          w_cnt   = '0;
        end else begin
          w_cnt = r_cnt + c_CW'(1);
        end
      end
      S_HELD: begin
        if (!w_hit) begin
          w_state = S_RELEASE;
          w_cnt   = c_CW'(1);
        end
      end
      default: begin
        if (w_hit) begin
          w_state = S_HELD;
          w_cnt   = '0;
        end else if (r_cnt == c_CNT_LAST) begin
          w_held  = 1'b0;
          w_state = S_SCAN;
          w_row   = r_row + 2'd1;
          w_sel   = {r_sel[2:0], r_sel[3]};
          w_dwell = '0;
          w_cnt   = '0;
        end else begin
          w_cnt = r_cnt + c_CW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge int_osc) begin
    if (reset) begin
      r_state   <= S_SCAN;
      r_dwell   <= '0;
      r_cnt     <= '0;
      r_row     <= 2'd0;
      r_col     <= 2'd0;
      r_sel     <= 4'b1110;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_dwell   <= w_dwell;
      r_cnt     <= w_cnt;
      r_row     <= w_row;
      r_col     <= w_col;
      r_sel     <= w_sel;
      key_code  <= w_code;
      key_valid <= w_valid;
      key_held  <= w_held;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_keypad_scan_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_keypad_scan_debounce: directed bench with a behavioural 4x4 keypad.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_keypad_scan_debounce;

  logic        int_osc;
  logic        reset;
  logic [3:0]  col_sync;
  logic [3:0]  r_sel;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [15:0] keys;
  int          n_checks;
  int          n_fail;
  int          n_strb;
  int          base;

  typedef struct {
    logic [1:0] row;
    logic [1:0] col;
    logic [3:0] code;
  } vec_t;
  vec_t tbl[16];

  keypad_scan_debounce #(.SCAN_DIV(4), .DB_CYCLES(3)) dut (
    .int_osc  (int_osc),
    .reset    (reset),
    .col_sync (col_sync),
    .r_sel    (r_sel),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_held (key_held)
  );

  initial begin
    int_osc = 1'b0;
    forever #5 int_osc = ~int_osc;
  end

  // A column reads low only while its key is down and its row is driven.
  always_comb begin
    col_sync = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !r_sel[r]) col_sync[c] = 1'b0;
  end

  always @(negedge int_osc) if (key_valid) n_strb++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic wait_valid(input string name);
    for (int i = 0; i < 80; i++) begin
      @(negedge int_osc);
      if (key_valid) break;
    end
    chk(name, {31'd0, key_valid}, 32'd1);
  endtask

  task automatic wait_release(input string name);
    for (int i = 0; i < 12; i++) begin
      @(negedge int_osc);
      if (!key_held) break;
    end
    chk(name, {31'd0, key_held}, 32'd0);
  endtask

  task automatic wait_sel(input logic [3:0] v);
    for (int i = 0; i < 40; i++) begin
      @(negedge int_osc);
      if (r_sel != v) break;
    end
    for (int i = 0; i < 40; i++) begin
      if (r_sel == v) break;
      @(negedge int_osc);
    end
    chk("wait_row", r_sel, v);
  endtask

  initial begin
    logic [3:0] sweep [5];
    n_checks = 0; n_fail = 0; n_strb = 0;
    keys = '0;
    sweep[0] = 4'b1110; sweep[1] = 4'b1101; sweep[2] = 4'b1011;
    sweep[3] = 4'b0111; sweep[4] = 4'b1110;
    tbl[0]  = '{2'd0, 2'd0, 4'h1}; tbl[1]  = '{2'd0, 2'd1, 4'h2};
    tbl[2]  = '{2'd0, 2'd2, 4'h3}; tbl[3]  = '{2'd0, 2'd3, 4'hA};
    tbl[4]  = '{2'd1, 2'd0, 4'h4}; tbl[5]  = '{2'd1, 2'd1, 4'h5};
    tbl[6]  = '{2'd1, 2'd2, 4'h6}; tbl[7]  = '{2'd1, 2'd3, 4'hB};
    tbl[8]  = '{2'd2, 2'd0, 4'h7}; tbl[9]  = '{2'd2, 2'd1, 4'h8};
    tbl[10] = '{2'd2, 2'd2, 4'h9}; tbl[11] = '{2'd2, 2'd3, 4'hC};
    tbl[12] = '{2'd3, 2'd0, 4'hE}; tbl[13] = '{2'd3, 2'd1, 4'h0};
    tbl[14] = '{2'd3, 2'd2, 4'hF}; tbl[15] = '{2'd3, 2'd3, 4'hD};

    // Reset and idle sweep
    reset = 1'b1;
    repeat (2) @(posedge int_osc);
    #1 reset = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge int_osc);
      chk("idle_sweep", {r_sel, key_valid, key_held}, {sweep[k/4], 1'b0, 1'b0});
    end
    chk("reset_code", key_code, 4'h0);

    // Clean press row 1 / column 0
    base = n_strb;
    keys[4] = 1'b1;
    wait_valid("clean_strobe");
    chk("clean_code", key_code, 4'h4);
    for (int k = 0; k < 36; k++) begin
      @(negedge int_osc);
      chk("clean_hold", {key_held, r_sel}, {1'b1, 4'b1101});
    end
    keys = '0;
    @(negedge int_osc); chk("clean_rel1", {key_held, r_sel}, {1'b1, 4'b1101});
    @(negedge int_osc); chk("clean_rel2", {key_held, r_sel}, {1'b1, 4'b1101});
    @(negedge int_osc); chk("clean_rel3", {key_held, r_sel}, {1'b0, 4'b1011});
    chk("clean_count", n_strb - base, 1);

    // Press bounce row 2 / column 2: one cycle low at the sampling edge
    wait_sel(4'b1011);
    base = n_strb;
    repeat (3) @(negedge int_osc);
    keys[10] = 1'b1;
    @(negedge int_osc);
    chk("bounce_frozen", r_sel, 4'b1011);
    keys = '0;
    @(negedge int_osc);
    chk("bounce_resume", r_sel, 4'b0111);
    repeat (4) @(negedge int_osc);
    chk("bounce_nostrobe", n_strb - base, 0);
    chk("bounce_held", {31'd0, key_held}, 32'd0);

    // Release bounce row 3 / column 1
    base = n_strb;
    keys[13] = 1'b1;
    wait_valid("rb_strobe");
    chk("rb_code", key_code, 4'h0);
    repeat (3) @(negedge int_osc);
    keys = '0;
    @(negedge int_osc); chk("rb_h1", {31'd0, key_held}, 32'd1);
    @(negedge int_osc); chk("rb_h2", {31'd0, key_held}, 32'd1);
    keys[13] = 1'b1;
    @(negedge int_osc); chk("rb_h3", {31'd0, key_held}, 32'd1);
    keys = '0;
    @(negedge int_osc); chk("rb_h4", {31'd0, key_held}, 32'd1);
    @(negedge int_osc); chk("rb_h5", {31'd0, key_held}, 32'd1);
    @(negedge int_osc); chk("rb_h6", {31'd0, key_held}, 32'd0);
    repeat (7) @(negedge int_osc);
    chk("rb_count", n_strb - base, 1);

    // Rollover and same-row priority
    base = n_strb;
    keys[3] = 1'b1;
    wait_valid("ro_strobe");
    chk("ro_code", key_code, 4'hA);
    keys[8] = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge int_osc);
      chk("ro_frozen", {key_held, r_sel}, {1'b1, 4'b1110});
    end
    chk("ro_count", n_strb - base, 1);
    keys = '0;
    wait_release("ro_release");
    keys[1] = 1'b1;
    keys[2] = 1'b1;
    wait_valid("prio_strobe");
    chk("prio_code", key_code, 4'h2);
    keys = '0;
    wait_release("prio_release");

    // Every key through the code map
    for (int i = 0; i < 16; i++) begin
      base = n_strb;
      keys[{tbl[i].row, tbl[i].col}] = 1'b1;
      wait_valid("tbl_strobe");
      chk("tbl_code", key_code, tbl[i].code);
      repeat (5) @(negedge int_osc);
      keys = '0;
      wait_release("tbl_release");
      chk("tbl_count", n_strb - base, 1);
    end

    // Reset while key 9 is held
    keys[10] = 1'b1;
    wait_valid("rst_strobe");
    chk("rst_code_pre", key_code, 4'h9);
    repeat (2) @(negedge int_osc);
    reset = 1'b1;
    @(negedge int_osc);
    chk("rst_outputs", {key_held, key_valid, key_code, r_sel}, {1'b0, 1'b0, 4'h0, 4'b1110});
    reset = 1'b0;
    base = n_strb;
    wait_valid("rst_restrobe");
    chk("rst_code_post", key_code, 4'h9);
    keys = '0;
    wait_release("rst_release");
    chk("rst_count", n_strb - base, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
